alu_control_mdu: RTL and testbench

- Parametrised successor to the combinational ALU control decoder.
- Decodes aluop/funct into ALU control, jr and a result-select code.
- Adds a sequential multiply/divide unit (MDU) with HI/LO registers and a pipeline stall interlock for MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO.
- Sits in the EX stage beside the ALU. Its stall output freezes IF/ID/EX.

---
 rtl/alu_control_mdu.sv | 201 ++++++++++++++++++++
 tb/tb_alu_control_mdu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with a sequential multiply/divide unit.
// Owns the HI/LO registers and raises a stall while an MDU op is in flight.
module alu_control_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [2:0]       alu_ctr,
  output logic             jr,
  output logic [1:0]       result_sel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d, dvz_q, dvz_d, neg_q, neg_d, rem_neg_q, rem_neg_d;

  // ---------------- decode ----------------
  always_comb begin
    alu_ctr = 3'b010;
    unique case (aluop)
      2'b00: alu_ctr = 3'b010;
      2'b01: alu_ctr = 3'b110;
      2'b11: alu_ctr = 3'b001;
      default: begin
        case (funct)
          F_ADD:   alu_ctr = 3'b010;
          F_SUB:   alu_ctr = 3'b110;
          F_AND:   alu_ctr = 3'b000;
          F_OR:    alu_ctr = 3'b001;
          F_SLT:   alu_ctr = 3'b111;
          default: alu_ctr = 3'b010;
        endcase
      end
    endcase
  end

  logic is_r, is_mul, is_div, is_mth, is_mtl, hazard;
  assign is_r       = (aluop == 2'b10);
  assign jr         = is_r && (funct == F_JR);
  assign result_sel = (is_r && funct == F_MFHI) ? 2'b01 :
                      (is_r && funct == F_MFLO) ? 2'b10 : 2'b00;
  assign is_mul     = is_r && (funct == F_MULT || funct == F_MULTU);
  assign is_div     = is_r && (funct == F_DIV  || funct == F_DIVU);
  assign is_mth     = is_r && (funct == F_MTHI);
  assign is_mtl     = is_r && (funct == F_MTLO);
  assign hazard     = is_mul || is_div || is_mth || is_mtl || (result_sel != 2'b00);

  assign busy  = (state_q != S_IDLE);
  assign stall = valid && busy && hazard;

  // ---------------- operand conditioning ----------------
  // Signed forms are the even function codes. The magnitude of the most-negative
  // value wraps to 2^(WIDTH-1), which is exactly representable unsigned.
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  assign rs_neg = ~funct[0] && rs_val[WIDTH-1];
  assign rt_neg = ~funct[0] && rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod      = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix  = neg_q ? -prod : prod;

  // ---------------- FSM next state ----------------
  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    dvz_d     = dvz_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid && (is_mul || is_div) && !stall) begin
          cnt_d     = '0;
          div_d     = is_div;
          dvz_d     = is_div && (rt_val == '0);
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          acc_hi_d  = '0;
          // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend.
          acc_lo_d  = is_mul ? rt_mag : rs_mag;
          opnd_d    = is_mul ? rs_mag : rt_mag;
          if (is_div && (rt_val == '0)) begin
            acc_lo_d = rs_val;
            state_d  = S_FIX;
          end else begin
            state_d  = S_RUN;
          end
        end else if (valid && is_mth) begin
          hi_d = rs_val;
        end else if (valid && is_mtl) begin
          lo_d = rs_val;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dvz_q) begin
          hi_d = acc_lo_q;
          lo_d = '1;
        end else if (div_q) begin
          hi_d = rem_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
          lo_d = neg_q     ? -acc_lo_q            : acc_lo_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: the iteration datapath is deliberately left without reset; it is always
  // loaded on op acceptance before it is read, so reset would only cost routing.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opnd_q    <= opnd_d;
    div_q     <= div_d;
    dvz_q     <= dvz_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode table, directed MDU corners,
// interlock and reset sequences, and randomized ops against an arithmetic model.
module tb_alu_control_mdu;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_n, valid;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic [2:0]   alu_ctr;
  logic         jr, stall, busy;
  logic [1:0]   result_sel;
  logic [W-1:0] hi, lo;

  alu_control_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .aluop(aluop), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctr(alu_ctr), .jr(jr),
    .result_sel(result_sel), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [2:0] alu_ctr;
    logic       jr;
    logic [1:0] rsel;
  } dec_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%'
  // takes the dividend's sign, matching the required signed divide.
  function automatic void ref_mdu(input logic [5:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output int cyc);
    longint sp, sq, sr;
    logic [63:0] ua, ub, up;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    cyc = W + 1;
    case (f)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      F_MULTU: begin
        up = ua * ub;
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      F_DIV, F_DIVU: begin
        if (b == '0) begin
          m_hi = a; m_lo = '1; cyc = 1;
        end else if (f == F_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          up = ua / ub; m_lo = up[31:0];
          up = ua % ub; m_hi = up[31:0];
        end
      end
      F_MTHI: begin m_hi = a; cyc = 0; end
      F_MTLO: begin m_lo = a; cyc = 0; end
      default: cyc = 0;
    endcase
  endfunction

  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    valid = 1'b1; aluop = 2'b10; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    valid = 1'b0; funct = 6'b100000;
  endtask

  task automatic wait_busy(output int n, output bit stable);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; stable = 1'b1;
    while (busy && n < 200) begin
      n++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [5:0] f,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    int exp_cyc, n;
    bit st;
    ref_mdu(f, a, b, exp_cyc);
    start_op(f, a, b);
    wait_busy(n, st);
    check($sformatf("%s busy_cycles", tag), n, exp_cyc);
    check($sformatf("%s hilo_stable", tag), st, 1);
    check($sformatf("%s hi", tag), hi, m_hi);
    check($sformatf("%s lo", tag), lo, m_lo);
  endtask

  // Presents op1, then holds op2 from the next cycle; op2 must stall until busy drops.
  task automatic interlock(input string tag, input logic [5:0] f1, input logic [W-1:0] a1,
                           input logic [W-1:0] b1, input logic [5:0] f2,
                           input logic [W-1:0] a2, input logic [W-1:0] b2,
                           output int n, output bit ok);
    int cyc;
    ref_mdu(f1, a1, b1, cyc);
    @(negedge clk);
    valid = 1'b1; aluop = 2'b10; funct = f1; rs_val = a1; rt_val = b1;
    @(negedge clk);
    funct = f2; rs_val = a2; rt_val = b2;
    #1;
    n = 0; ok = 1'b1;
    while (busy && n < 200) begin
      if (stall !== 1'b1) ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
    check($sformatf("%s stall_cycles", tag), n, cyc);
    check($sformatf("%s stall_held", tag), ok, 1);
    check($sformatf("%s stall_released", tag), stall, 0);
    check($sformatf("%s first_hi", tag), hi, m_hi);
    check($sformatf("%s first_lo", tag), lo, m_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t     dec_tab[14];
    logic [5:0]   ops[6];
    logic [5:0]   f;
    logic [W-1:0] a, b;
    int           n, cyc;
    bit           ok, st;

    dec_tab[0]  = '{2'b00, 6'b100010, 3'b010, 1'b0, 2'b00};
    dec_tab[1]  = '{2'b01, 6'b000000, 3'b110, 1'b0, 2'b00};
    dec_tab[2]  = '{2'b11, 6'b100000, 3'b001, 1'b0, 2'b00};
    dec_tab[3]  = '{2'b10, 6'b100000, 3'b010, 1'b0, 2'b00};
    dec_tab[4]  = '{2'b10, 6'b100010, 3'b110, 1'b0, 2'b00};
    dec_tab[5]  = '{2'b10, 6'b100100, 3'b000, 1'b0, 2'b00};
    dec_tab[6]  = '{2'b10, 6'b100101, 3'b001, 1'b0, 2'b00};
    dec_tab[7]  = '{2'b10, 6'b101010, 3'b111, 1'b0, 2'b00};
    dec_tab[8]  = '{2'b10, 6'b001000, 3'b010, 1'b1, 2'b00};
    dec_tab[9]  = '{2'b10, 6'b010000, 3'b010, 1'b0, 2'b01};
    dec_tab[10] = '{2'b10, 6'b010010, 3'b010, 1'b0, 2'b10};
    dec_tab[11] = '{2'b10, 6'b011000, 3'b010, 1'b0, 2'b00};
    dec_tab[12] = '{2'b01, 6'b001000, 3'b110, 1'b0, 2'b00};
    dec_tab[13] = '{2'b00, 6'b010010, 3'b010, 1'b0, 2'b00};
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    rst_n = 1'b0; valid = 1'b0; aluop = 2'b00; funct = 6'b0;
    rs_val = '0; rt_val = '0; m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1; aluop = 2'b10; funct = F_MFHI;
    #1;
    check("reset busy", busy, 0);
    check("reset stall", stall, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    valid = 1'b0;

    // Decode sweep with valid low: must not start anything even for MULT.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      aluop = dec_tab[i].aluop; funct = dec_tab[i].funct;
      rs_val = 32'h0000_0009; rt_val = 32'h0000_0003;
      #1;
      check($sformatf("dec[%0d] alu_ctr", i), alu_ctr, dec_tab[i].alu_ctr);
      check($sformatf("dec[%0d] jr", i), jr, dec_tab[i].jr);
      check($sformatf("dec[%0d] result_sel", i), result_sel, dec_tab[i].rsel);
    end
    @(negedge clk);
    check("valid_low ignored busy", busy, 0);
    check("valid_low ignored lo", lo, 0);

    // Directed corners.
    run_and_check("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_max hi const", hi, 32'h0000_0001);
    check("multu_max lo const", lo, 32'hFFFF_FFFE);
    run_and_check("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_m7_2 lo const", lo, 32'hFFFF_FFFD);
    check("div_m7_2 hi const", hi, 32'hFFFF_FFFF);
    run_and_check("mult_m3_5", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mult_m3_5 lo const", lo, 32'hFFFF_FFF1);
    run_and_check("divu_zero", F_DIVU, 32'h1234_5678, 32'h0000_0000);
    check("divu_zero hi const", hi, 32'h1234_5678);
    run_and_check("div_zero_neg", F_DIV, 32'h8000_0003, 32'h0000_0000);
    run_and_check("div_minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg lo const", lo, 32'h8000_0000);
    check("div_minneg hi const", hi, 32'h0000_0000);
    run_and_check("mult_minneg", F_MULT, 32'h8000_0000, 32'h8000_0000);
    run_and_check("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);

    // Interlock: dependent MFLO stalls, then is accepted with the new LO.
    interlock("ilock_mflo", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005,
              F_MFLO, 32'h0, 32'h0, n, ok);
    check("ilock_mflo result_sel", result_sel, 2'b10);
    check("ilock_mflo lo const", lo, 32'hFFFF_FFF1);
    @(negedge clk);
    valid = 1'b0;
    check("ilock_mflo no restart", busy, 0);

    // Interlock: a second MULT issued while busy stalls, then runs.
    interlock("ilock_mult", F_MULTU, 32'h0001_0000, 32'h0001_0001,
              F_MULT, 32'hFFFF_FFFF, 32'h0000_0007, n, ok);
    @(negedge clk);
    valid = 1'b0;
    ref_mdu(F_MULT, 32'hFFFF_FFFF, 32'h0000_0007, cyc);
    wait_busy(n, st);
    check("ilock_mult second cycles", n, cyc);
    check("ilock_mult second hi", hi, m_hi);
    check("ilock_mult second lo", lo, m_lo);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = W'($urandom_range(1, 15));
        3: b = -W'($urandom_range(1, 15));
        default: ;
      endcase
      run_and_check($sformatf("rnd[%0d] f=%0b", i, f), f, a, b);
    end

    // Reset during RUN discards the op and clears HI/LO.
    start_op(F_MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (4) @(negedge clk);
    check("midrun busy before reset", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    valid = 1'b1; aluop = 2'b10; funct = F_MFLO;
    #1;
    check("midrun reset busy", busy, 0);
    check("midrun reset stall", stall, 0);
    check("midrun reset hi", hi, 0);
    check("midrun reset lo", lo, 0);
    valid = 1'b0;
    run_and_check("post_reset mthi", F_MTHI, 32'hA5A5_A5A5, 32'h0);
    check("post_reset mthi const", hi, 32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    check("post_reset idle hi", hi, 32'hA5A5_A5A5);
    check("post_reset idle lo", lo, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
